irq_request_gen: RTL

//  Peripheral-side end of the interrupt request/finish handshake. Turns raw per-device

---
 rtl/irq_request_gen_pkg.sv | 15 +
 rtl/irq_request_gen_channel.sv | 107 ++++++++++
 rtl/irq_request_gen.sv | 53 +++++
 3 files changed

// File: rtl/irq_request_gen_pkg.sv
// Shared types and defaults for the interrupt request generator.
// Channel FSM encoding is fixed so waveforms read the same across builds.
package irq_request_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } ch_state_e;

    localparam int N_CH_DEF       = 6;
    localparam int CNT_W_DEF      = 4;
    localparam int GAP_CYCLES_DEF = 2;

endpackage

// File: rtl/irq_request_gen_channel.sv
// One interrupt channel: request FSM, pending-event counter, low-gap timer
// and sticky overflow flag. Events arrive already edge-detected.
module irq_channel
    import irq_request_gen_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ev_i,
    input  logic fin_i,
    input  logic ovf_clr_i,
    output logic req_o,
    output logic busy_o,
    output logic ovf_o
);

    localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    ch_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [GAP_W-1:0] gap_ctr_q;
    logic             req_q;
    logic             busy_q;
    logic             ovf_q;

    logic             cnt_full;
    logic [CNT_W-1:0] cnt_sat_inc;
    logic             ovf_set;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        cnt_full    = (cnt_q == CNT_MAX);
        cnt_sat_inc = cnt_full ? cnt_q : cnt_q + 1'b1;
        // An event that coincides with a finish nets to zero and is never an overflow.
        ovf_set     = ev_i && cnt_full && !((state_q == ST_REQ) && fin_i);
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            gap_ctr_q <= '0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ev_i) begin
                        cnt_q   <= CNT_W'(1);
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (fin_i) begin
                        req_q <= 1'b0;
                        if ((cnt_q == CNT_W'(1)) && !ev_i) begin
                            cnt_q   <= '0;
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q     <= ev_i ? cnt_q : cnt_q - 1'b1;
                            gap_ctr_q <= GAP_LOAD;
                            state_q   <= ST_GAP;
                        end
                    end else if (ev_i) begin
                        cnt_q <= cnt_sat_inc;
                    end
                end
                ST_GAP: begin
                    if (ev_i) begin
                        cnt_q <= cnt_sat_inc;
                    end
                    if (gap_ctr_q == '0) begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                    end else begin
                        gap_ctr_q <= gap_ctr_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase

            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr_i) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign req_o  = req_q;
    assign busy_o = busy_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/irq_request_gen.sv
// Turns raw peripheral event lines into held interrupt requests, one
// independent channel per line, released by the controller's finish pulse.
module irq_request_gen
    import irq_request_gen_pkg::*;
#(
    parameter int N_CH       = N_CH_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] event_i,
    input  logic [N_CH-1:0] int_fin_i,
    input  logic            ovf_clr_i,
    output logic [N_CH-1:0] int_req_o,
    output logic [N_CH-1:0] ovf_o,
    output logic            busy_o
);

    logic [N_CH-1:0] event_q;
    logic [N_CH-1:0] ev;
    logic [N_CH-1:0] busy_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_q <= '0;
        end else begin
            event_q <= event_i;
        end
    end

    // A level held high produces a single event on its rising edge.
    assign ev = event_i & ~event_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        irq_channel #(
            .CNT_W      (CNT_W),
            .GAP_CYCLES (GAP_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .ev_i      (ev[i]),
            .fin_i     (int_fin_i[i]),
            .ovf_clr_i (ovf_clr_i),
            .req_o     (int_req_o[i]),
            .busy_o    (busy_vec[i]),
            .ovf_o     (ovf_o[i])
        );
    end

    assign busy_o = |busy_vec;

endmodule
